// File: rtl/bg_rect_writer_if.sv
// Bus between the loader/score-update logic (master) and the background
// rectangle writer (slave): descriptor, pixel stream and memory write port.
interface bg_rect_writer_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [1:0]        region;
   logic [9:0]        rect_x;
   logic [9:0]        rect_y;
   logic [9:0]        rect_w;
   logic [9:0]        rect_h;
   logic              abort;
   logic              pix_valid;
   logic [DATA_W-1:0] pix_data;
   logic              pix_ready;
   logic              we;
   logic [1:0]        wr_region;
   logic [18:0]       wr_address;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, region, rect_x, rect_y, rect_w, rect_h, abort, pix_valid, pix_data,
      input  pix_ready, we, wr_region, wr_address, wr_data, busy, done, err
   );

   modport slave (
      input  start, region, rect_x, rect_y, rect_w, rect_h, abort, pix_valid, pix_data,
      output pix_ready, we, wr_region, wr_address, wr_data, busy, done, err
   );
endinterface

// File: rtl/bg_rect_writer.sv
// Fills an in-bounds sub-rectangle of a background region in raster order,
// turning a valid/ready pixel stream into registered linear-address writes.
module bg_rect_writer #(
   parameter int DATA_W   = 8,
   parameter int REGION_W = 320,
   parameter int MAP_H    = 480,
   parameter int SCORE_H  = 240
) (
   input logic            Clk,
   input logic            Reset,
   bg_rect_writer_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [10:0] REGION_W_C = 11'(REGION_W);
   localparam logic [10:0] MAP_H_C    = 11'(MAP_H);
   localparam logic [10:0] SCORE_H_C  = 11'(SCORE_H);
   localparam logic [18:0] PITCH_C    = 19'(REGION_W);

   state_t            state_r;
   logic [1:0]        region_r;
   logic [9:0]        w_r;
   logic [9:0]        h_r;
   logic [9:0]        col_r;
   logic [9:0]        row_r;
   logic [18:0]       row_base_r;
   logic              we_r;
   logic [1:0]        wr_region_r;
   logic [18:0]       wr_address_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              done_r;
   logic              err_r;

   logic [10:0]       x_end_s;
   logic [10:0]       y_end_s;
   logic [10:0]       y_lim_s;
   logic              start_ok_s;
   logic [18:0]       launch_base_s;
   logic              ready_s;
   logic              xfer_s;
   logic              col_last_s;
   logic              row_last_s;

   // Launch validation: bounds sums are 11 bits wide so they cannot wrap.
   always_comb begin
      x_end_s = {1'b0, bus.rect_x} + {1'b0, bus.rect_w};
      y_end_s = {1'b0, bus.rect_y} + {1'b0, bus.rect_h};
      case (bus.region)
         2'd1:       y_lim_s = MAP_H_C;
         2'd2, 2'd3: y_lim_s = SCORE_H_C;
         default:    y_lim_s = 11'd0;
      endcase
      start_ok_s = (bus.region != 2'd0) && (bus.rect_w != 10'd0) && (bus.rect_h != 10'd0) &&
                   (x_end_s <= REGION_W_C) && (y_end_s <= y_lim_s);
      // Multiply only once at launch; rows advance by addition afterwards.
      launch_base_s = 19'(bus.rect_y) * PITCH_C + 19'(bus.rect_x);
   end

   // Transfer and raster-position decode.
   always_comb begin
      ready_s    = (state_r == RUN);
      xfer_s     = bus.pix_valid && ready_s;
      col_last_s = (col_r == (w_r - 10'd1));
      row_last_s = (row_r == (h_r - 10'd1));
   end

   // Control FSM, raster counters and registered write port.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r      <= IDLE;
         region_r     <= 2'd0;
         w_r          <= 10'd0;
         h_r          <= 10'd0;
         col_r        <= 10'd0;
         row_r        <= 10'd0;
         row_base_r   <= 19'd0;
         we_r         <= 1'b0;
         wr_region_r  <= 2'd0;
         wr_address_r <= 19'd0;
         wr_data_r    <= '0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         we_r   <= 1'b0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if (start_ok_s) begin
                     region_r   <= bus.region;
                     w_r        <= bus.rect_w;
                     h_r        <= bus.rect_h;
                     col_r      <= 10'd0;
                     row_r      <= 10'd0;
                     row_base_r <= launch_base_s;
                     state_r    <= RUN;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state_r <= IDLE;
               end else if (xfer_s) begin
                  we_r         <= 1'b1;
                  wr_address_r <= row_base_r + 19'(col_r);
                  wr_data_r    <= bus.pix_data;
                  wr_region_r  <= region_r;
                  if (col_last_s) begin
                     col_r      <= 10'd0;
                     row_r      <= row_r + 10'd1;
                     row_base_r <= row_base_r + PITCH_C;
                     if (row_last_s) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                     end
                  end else begin
                     col_r <= col_r + 10'd1;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.pix_ready  = ready_s;
   assign bus.busy       = ready_s;
   assign bus.we         = we_r;
   assign bus.wr_region  = wr_region_r;
   assign bus.wr_address = wr_address_r;
   assign bus.wr_data    = wr_data_r;
   assign bus.done       = done_r;
   assign bus.err        = err_r;

endmodule

// File: tb/tb_bg_rect_writer.sv
// Directed bench for bg_rect_writer: a pixel-count model predicts every output
// cycle by cycle, and literal address lists pin the model for each scenario.
module tb_bg_rect_writer;

   logic Clk;
   logic Reset;

   bg_rect_writer_if #(.DATA_W(8)) bus ();

   bg_rect_writer #(.DATA_W(8), .REGION_W(320), .MAP_H(480), .SCORE_H(240)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Model state: pixel index k within the rectangle gives the address directly.
   bit   m_active;
   int   m_x, m_y, m_w, m_h, m_k, m_lim;
   int   m_reg;
   bit   started;
   logic        e_we, e_done, e_err;
   logic [18:0] e_addr;
   logic [7:0]  e_data;
   logic [1:0]  e_region;

   always @(posedge Clk) begin
      if (Reset) begin
         m_active = 1'b0; m_k = 0;
         e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
         e_addr = 19'd0; e_data = 8'd0; e_region = 2'd0;
      end else begin
         e_we = 1'b0; e_done = 1'b0; e_err = 1'b0;
         if (!m_active) begin
            if (bus.start) begin
               m_lim = (bus.region == 2'd1) ? 480 : 240;
               if (bus.region != 2'd0 && bus.rect_w != 10'd0 && bus.rect_h != 10'd0 &&
                   int'(bus.rect_x) + int'(bus.rect_w) <= 320 &&
                   int'(bus.rect_y) + int'(bus.rect_h) <= m_lim) begin
                  m_x = int'(bus.rect_x); m_y = int'(bus.rect_y);
                  m_w = int'(bus.rect_w); m_h = int'(bus.rect_h);
                  m_reg = int'(bus.region); m_k = 0; m_active = 1'b1;
               end else begin
                  e_err = 1'b1;
               end
            end
         end else if (bus.abort) begin
            m_active = 1'b0;
         end else if (bus.pix_valid) begin
            e_we     = 1'b1;
            e_addr   = 19'((m_y + m_k / m_w) * 320 + m_x + m_k % m_w);
            e_data   = bus.pix_data;
            e_region = 2'(m_reg);
            if (m_k == m_w * m_h - 1) begin
               e_done   = 1'b1;
               m_active = 1'b0;
            end
            m_k++;
         end
      end
      started = 1'b1;
   end

   int          log_addr[$];
   logic [7:0]  log_data[$];
   logic [1:0]  log_reg[$];
   bit          log_done[$];
   int          done_cnt, err_cnt;

   // Per-cycle compare against the model, plus a write log for literal checks.
   always @(negedge Clk) begin
      if (started) begin
         check("we", 32'(bus.we), 32'(e_we));
         check("done", 32'(bus.done), 32'(e_done));
         check("err", 32'(bus.err), 32'(e_err));
         check("busy", 32'(bus.busy), 32'(m_active));
         check("pix_ready", 32'(bus.pix_ready), 32'(m_active));
         check("wr_address", 32'(bus.wr_address), 32'(e_addr));
         check("wr_data", 32'(bus.wr_data), 32'(e_data));
         check("wr_region", 32'(bus.wr_region), 32'(e_region));
         if (bus.we === 1'b1) begin
            log_addr.push_back(int'(bus.wr_address));
            log_data.push_back(bus.wr_data);
            log_reg.push_back(bus.wr_region);
            log_done.push_back(bus.done);
         end
         if (bus.done === 1'b1) done_cnt++;
         if (bus.err === 1'b1) err_cnt++;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_data.delete(); log_reg.delete(); log_done.delete();
      done_cnt = 0; err_cnt = 0;
   endtask

   task automatic launch(input logic [1:0] r, input int x, input int y, input int w, input int h);
      bus.start = 1'b1; bus.region = r;
      bus.rect_x = 10'(x); bus.rect_y = 10'(y); bus.rect_w = 10'(w); bus.rect_h = 10'(h);
      tick();
      bus.start = 1'b0;
   endtask

   // Drive n cycles of pixels; bit i of vpat is pix_valid in cycle i.
   task automatic feed(input int n, input logic [31:0] vpat, input logic [7:0] d0);
      for (int i = 0; i < n; i++) begin
         bus.pix_valid = vpat[i];
         bus.pix_data  = d0 + 8'(i);
         tick();
      end
      bus.pix_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_addrs(input string name, input int exp[4], input int n);
      check({name, " count"}, 32'(log_addr.size()), 32'(n));
      for (int i = 0; i < n; i++)
         if (i < log_addr.size()) check(name, 32'(log_addr[i]), 32'(exp[i]));
   endtask

   initial begin
      Reset = 1'b1;
      bus.start = 1'b0; bus.region = 2'd0;
      bus.rect_x = 10'd0; bus.rect_y = 10'd0; bus.rect_w = 10'd0; bus.rect_h = 10'd0;
      bus.abort = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = 8'd0;
      done_cnt = 0; err_cnt = 0;
      tick(); tick();
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset we", 32'(bus.we), 32'd0);
      check("reset addr", 32'(bus.wr_address), 32'd0);
      Reset = 1'b0;
      tick();

      // Map 2x2 at origin.
      clear_logs();
      launch(2'd1, 0, 0, 2, 2);
      feed(4, 32'hF, 8'hA0);
      check_addrs("map2x2 addr", '{0, 1, 320, 321}, 4);
      if (log_data.size() == 4) check("map2x2 last data", 32'(log_data[3]), 32'hA3);
      if (log_done.size() == 4) check("map2x2 done on 4th", 32'(log_done[3]), 32'd1);
      check("map2x2 done count", 32'(done_cnt), 32'd1);

      // Score panel 1 bottom-right corner.
      clear_logs();
      launch(2'd2, 318, 238, 2, 2);
      feed(4, 32'hF, 8'h10);
      check_addrs("score1 addr", '{76478, 76479, 76798, 76799}, 4);
      if (log_reg.size() == 4) check("score1 region", 32'(log_reg[2]), 32'd2);
      check("score1 done count", 32'(done_cnt), 32'd1);
      check("score1 err count", 32'(err_cnt), 32'd0);

      // Illegal starts.
      clear_logs();
      launch(2'd0, 0, 0, 1, 1);   tick();
      launch(2'd1, 300, 0, 21, 1); tick();
      launch(2'd3, 0, 200, 1, 41); tick();
      launch(2'd1, 0, 0, 0, 1);   tick();
      bus.pix_valid = 1'b1; tick(); bus.pix_valid = 1'b0; tick();
      check("illegal err count", 32'(err_cnt), 32'd4);
      check("illegal we count", 32'(log_addr.size()), 32'd0);

      // Backpressure 3x1 at (10,5): base 1610.
      clear_logs();
      launch(2'd1, 10, 5, 3, 1);
      feed(5, 32'b10101, 8'h30);
      check_addrs("bp addr", '{1610, 1611, 1612, 0}, 3);
      if (log_done.size() == 3) check("bp done on 3rd", 32'(log_done[2]), 32'd1);
      if (log_data.size() == 3) check("bp data 3rd", 32'(log_data[2]), 32'h34);
      check("bp done count", 32'(done_cnt), 32'd1);

      // Abort after 5 of 16; the abort cycle's pixel is discarded.
      clear_logs();
      launch(2'd1, 0, 0, 4, 4);
      for (int i = 0; i < 5; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(i); tick();
      end
      bus.abort = 1'b1; tick();
      bus.abort = 1'b0; bus.pix_valid = 1'b0; tick(); tick();
      check("abort we count", 32'(log_addr.size()), 32'd5);
      check("abort done count", 32'(done_cnt), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
      clear_logs();
      launch(2'd1, 7, 7, 1, 1);
      feed(1, 32'h1, 8'h77);
      check_addrs("post-abort addr", '{2247, 0, 0, 0}, 1);
      check("post-abort done", 32'(done_cnt), 32'd1);

      // Reset mid full-map fill, with start held during reset.
      clear_logs();
      launch(2'd1, 0, 0, 320, 480);
      for (int i = 0; i < 20; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 8'(i); tick();
      end
      Reset = 1'b1; bus.start = 1'b1; tick();
      check("midreset we", 32'(bus.we), 32'd0);
      check("midreset busy", 32'(bus.busy), 32'd0);
      check("midreset ready", 32'(bus.pix_ready), 32'd0);
      tick(); tick();
      check("reset-held busy", 32'(bus.busy), 32'd0);
      Reset = 1'b0; bus.start = 1'b0; bus.pix_valid = 1'b0; tick();
      check("full map partial writes", 32'(log_addr.size()), 32'd20);
      clear_logs();
      launch(2'd1, 319, 479, 1, 1);
      feed(1, 32'h1, 8'h5A);
      check_addrs("last pixel addr", '{153599, 0, 0, 0}, 1);
      check("last pixel done", 32'(done_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
